// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared types and constants for the pipeline boundary registers
package rv_pipe_pkg;

    localparam int RV_XLEN = 64;
    localparam int RV_ILEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID boundary register with 2-entry skid buffer, flush and event counters
module if_id_skid_reg
    import rv_pipe_pkg::*;
#(
    parameter int               XLEN      = RV_XLEN,
    parameter int               ILEN      = RV_ILEN,
    parameter int               CNT_W     = 32,
    parameter logic [ILEN-1:0]  NOP_INSTR = ILEN'(RV_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [ILEN-1:0]   in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [ILEN-1:0]   out_instr,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    skid_state_t       state_q;
    skid_state_t       state_d;
    logic [XLEN-1:0]   main_pc;
    logic [ILEN-1:0]   main_instr;
    logic [XLEN-1:0]   skid_pc;
    logic [ILEN-1:0]   skid_instr;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides every transition and suppresses all payload captures.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: load_main_in = 1'b1;
                        2'b10: begin
                            state_d   = TWO;
                            load_skid = 1'b1;
                        end
                        2'b01: state_d = EMPTY;
                        default: state_d = ONE;
                    endcase
                end
                TWO: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Both handshake outputs decode the state register only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
        out_pc    = main_pc;
        out_instr = (state_q != EMPTY) ? main_instr : NOP_INSTR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            if (load_main_in) begin
                main_pc    <= in_pc;
                main_instr <= in_instr;
            end else if (load_main_skid) begin
                main_pc    <= skid_pc;
                main_instr <= skid_instr;
            end
            if (load_skid) begin
                skid_pc    <= in_pc;
                skid_instr <= in_instr;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush && out_valid),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed self-checking bench for if_id_skid_reg
module tb_if_id_skid_reg;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [ILEN-1:0]  in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [ILEN-1:0]  out_instr;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_skid_reg #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'hDEAD;
        in_instr  = 32'hBEEF;
        out_ready = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'h13);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // streaming: each beat visible one cycle after presentation
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_pc    = 64'h1000 + 64'(4 * k);
            in_instr = 32'hA0 + 32'(k);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", out_pc, 64'h1000 + 64'(4 * k));
            check("stream_instr", 64'(out_instr), 64'hA0 + 64'(k));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_drain_nop", 64'(out_instr), 64'h13);
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // skid fill
        in_valid = 1'b1;
        in_pc    = 64'h2000;
        in_instr = 32'h200;
        tick();
        check("skid_head_pc", out_pc, 64'h2000);
        out_ready = 1'b0;
        in_pc     = 64'h2004;
        in_instr  = 32'h204;
        tick();
        check("skid_in_ready_low", 64'(in_ready), 64'd0);
        check("skid_head_held", out_pc, 64'h2000);
        in_pc    = 64'h2008;
        in_instr = 32'h208;
        tick();
        tick();
        check("skid_stall_cnt3", 64'(stall_cnt), 64'd3);
        check("skid_still_full", 64'(in_ready), 64'd0);
        check("skid_head_still", out_pc, 64'h2000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("skid_drain_pc", out_pc, 64'h2004);
        check("skid_drain_instr", 64'(out_instr), 64'h204);
        check("skid_drain_valid", 64'(out_valid), 64'd1);
        check("skid_in_ready_back", 64'(in_ready), 64'd1);
        tick();
        check("skid_empty", 64'(out_valid), 64'd0);
        check("skid_stall_final", 64'(stall_cnt), 64'd3);

        // flush with skid full and fetch still presenting
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h3000;
        in_instr  = 32'h300;
        tick();
        in_pc    = 64'h3004;
        in_instr = 32'h304;
        tick();
        check("flush_pre_full", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_pc    = 64'h3008;
        in_instr = 32'h308;
        tick();
        check("flush_two_valid", 64'(out_valid), 64'd0);
        check("flush_two_nop", 64'(out_instr), 64'h13);
        check("flush_two_in_ready", 64'(in_ready), 64'd1);
        check("flush_two_cnt", 64'(flush_cnt), 64'd1);
        check("flush_two_stall", 64'(stall_cnt), 64'd5);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("flush_two_gone", 64'(out_valid), 64'd0);

        // flush in ONE with a beat accepted in the same cycle
        in_valid = 1'b1;
        in_pc    = 64'h4000;
        in_instr = 32'h400;
        tick();
        check("flush_one_head", out_pc, 64'h4000);
        flush    = 1'b1;
        in_pc    = 64'h4004;
        in_instr = 32'h404;
        tick();
        check("flush_one_valid", 64'(out_valid), 64'd0);
        check("flush_one_cnt", 64'(flush_cnt), 64'd2);
        check("flush_one_stale_pc", out_pc, 64'h4000);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_one_discarded", 64'(out_valid), 64'd0);

        // flush while empty does not count
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_cnt", 64'(flush_cnt), 64'd2);
        check("flush_empty_ready", 64'(in_ready), 64'd1);

        // asynchronous reset clears counters and held entry
        in_valid = 1'b1;
        in_pc    = 64'h4800;
        in_instr = 32'h480;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_pc", out_pc, 64'd0);
        check("async_rst_flush_cnt", 64'(flush_cnt), 64'd0);
        check("async_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        tick();
        rst = 1'b0;

        // saturation of the 3-bit stall counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h5000;
        in_instr  = 32'h500;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("sat_stall_6", 64'(stall_cnt), 64'd6);
        for (int i = 0; i < 4; i++) tick();
        check("sat_stall_10", 64'(stall_cnt), 64'd7);
        check("sat_head_held", out_pc, 64'h5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised IF/ID boundary register with a valid/ready handshake on both sides, a 2-entry skid buffer, a synchronous flush and saturating stall/flush event counters. Sits between the fetch stage (PC + instruction) and decode. Registered outputs and a registered `in_ready` break the ready path, so decode back-pressure never reaches fetch combinationally. Decode sees a NOP whenever no valid instruction is held.

## Interface
Parameters:
- `XLEN`, 64: PC width.
- `ILEN`, 32: instruction width.
- `CNT_W`, 32: event counter width.
- `NOP_INSTR`, `32'h0000_0013`: instruction presented while `out_valid`=0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch has a beat.
- `in_ready`  out  1  register can accept a beat (registered).
- `in_pc`  in  XLEN  fetch PC.
- `in_instr`  in  ILEN  fetch instruction.
- `out_valid`  out  1  decode beat valid.
- `out_ready`  in  1  decode accepts the beat.
- `out_pc`  out  XLEN  PC of the head entry.
- `out_instr`  out  ILEN  head instruction, or `NOP_INSTR` when `out_valid`=0.
- `flush`  in  1  drop all held entries (branch/exception redirect).
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`.
- `flush_cnt`  out  CNT_W  flush cycles that dropped at least one valid entry.

## Operation
- Fire rules: in-fire = `in_valid && in_ready`; out-fire = `out_valid && out_ready`.
- Storage: main slot (head, drives the outputs) and skid slot.
- State machine `EMPTY` / `ONE` / `TWO`:
  - `EMPTY`: in-fire → `ONE`, main ← input.
  - `ONE`, in-fire and out-fire → `ONE`, main ← input.
  - `ONE`, in-fire only → `TWO`, skid ← input.
  - `ONE`, out-fire only → `EMPTY`.
  - `ONE`, neither → hold.
  - `TWO`: `in_ready`=0; out-fire → `ONE`, main ← skid; otherwise hold.
- Derived outputs: `in_ready` = (state != `TWO`); `out_valid` = (state != `EMPTY`).
- Ordering: strict FIFO. Each accepted beat appears exactly once at the output unless flushed.
- Flush: `flush`=1 at a clock edge forces `EMPTY`. Priority over every other transition. A beat accepted (in-fire) in the same cycle is discarded. An out-fire in the flush cycle still counts as delivered to decode.
- Payload: slot payload registers are written only on capture and keep their value otherwise. `out_pc` shows the stale main PC when invalid.
- `stall_cnt`: +1 each cycle with `out_valid && !out_ready`; saturates at all-ones.
- `flush_cnt`: +1 each cycle with `flush && out_valid`; saturates at all-ones.
- Counters clear only on `rst`.

## Timing
- Reset values: state `EMPTY`, `in_ready`=1, `out_valid`=0, `out_pc`=0, `out_instr`=`NOP_INSTR`, both counters 0, skid payload 0.
- Latency: input beat to `out_valid` is 1 cycle.
- Throughput: 1 beat/cycle with `out_ready` held high; stays in `ONE`.
- Back-pressure: `in_ready` falls 1 cycle after the edge that fills the skid slot, and rises 1 cycle after the edge that drains it. Once `out_ready` drops, at most one further beat is accepted.
- Combinational paths: none from `out_ready` to `in_ready`. `out_instr` has only the NOP mux on `out_valid`.
- Reset mid-operation: `rst` asserted in any state clears everything immediately (asynchronous). Held entries are lost and do not count as flushes.
- Simultaneous `flush` and `rst`: `rst` wins.

## Structure
- Shared package `rv_pipe_pkg` holds:
  - `skid_state_t` enum (`EMPTY`, `ONE`, `TWO`).
  - `RV_NOP` constant (`32'h0000_0013`), used as the `NOP_INSTR` default.
  - The default XLEN/ILEN constants shared with the other pipeline registers.
- One sub-module, `sat_counter`: parameter `W`; ports `clk`, `rst`, `inc`, `count`. Instantiated twice.

## Test plan
- Reset: assert `rst` with `in_valid`=1 → `in_ready`=1, `out_valid`=0, `out_instr`=0x13, `out_pc`=0, counters 0.
- Streaming: 8 beats (PC 0x1000+4k, instr 0xA0+k) with `out_ready`=1 → each appears 1 cycle later in order; `in_ready` stays 1; `stall_cnt`=0.
- Skid fill: drop `out_ready` with PC 0x2000 at the head and PC 0x2004 arriving:
  - 0x2004 captured, then `in_ready`=0.
  - After 3 stalled cycles, `stall_cnt`=3.
  - Raise `out_ready` → outputs 0x2000 then 0x2004; `in_ready` back to 1.
- Flush in `TWO` with an in-fire pending → next cycle `out_valid`=0, `out_instr`=0x13, `in_ready`=1, `flush_cnt`=1. The discarded beats never appear.
- Flush while `EMPTY` → `flush_cnt` unchanged.
- Saturation (`CNT_W`=3): hold a stall for 10 cycles → `stall_cnt` stops at 7.
